// File: rtl/sap1_controller_sequencer_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer: opcodes, control-word
// bit positions, named control words, one-hot ring states and the control
// word decode.
package sap1_controller_sequencer_pkg;

  localparam int unsigned CON_W = 12;
  localparam int unsigned T_W   = 6;
  localparam int unsigned OP_W  = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Control word bit positions (N suffix = active-low)
  localparam int unsigned CON_CP   = 11;
  localparam int unsigned CON_EP   = 10;
  localparam int unsigned CON_LM_N = 9;
  localparam int unsigned CON_CE_N = 8;
  localparam int unsigned CON_LI_N = 7;
  localparam int unsigned CON_EI_N = 6;
  localparam int unsigned CON_LA_N = 5;
  localparam int unsigned CON_EA   = 4;
  localparam int unsigned CON_SU   = 3;
  localparam int unsigned CON_EU   = 2;
  localparam int unsigned CON_LB_N = 1;
  localparam int unsigned CON_LO_N = 0;

  localparam logic [CON_W-1:0] ONE = CON_W'(1);

  // Every named word is the idle word with the asserted controls flipped.
  localparam logic [CON_W-1:0] CON_IDLE     = 12'h3E3;
  localparam logic [CON_W-1:0] CON_FETCH_T1 = CON_IDLE ^ ((ONE << CON_EP) | (ONE << CON_LM_N));
  localparam logic [CON_W-1:0] CON_FETCH_T2 = CON_IDLE ^ (ONE << CON_CP);
  localparam logic [CON_W-1:0] CON_FETCH_T3 = CON_IDLE ^ ((ONE << CON_CE_N) | (ONE << CON_LI_N));
  localparam logic [CON_W-1:0] CON_IR_MAR   = CON_IDLE ^ ((ONE << CON_LM_N) | (ONE << CON_EI_N));
  localparam logic [CON_W-1:0] CON_LDA_T5   = CON_IDLE ^ ((ONE << CON_CE_N) | (ONE << CON_LA_N));
  localparam logic [CON_W-1:0] CON_LOAD_B   = CON_IDLE ^ ((ONE << CON_CE_N) | (ONE << CON_LB_N));
  localparam logic [CON_W-1:0] CON_ADD_T6   = CON_IDLE ^ ((ONE << CON_LA_N) | (ONE << CON_EU));
  localparam logic [CON_W-1:0] CON_SUB_T6   = CON_ADD_T6 ^ (ONE << CON_SU);
  localparam logic [CON_W-1:0] CON_OUT_T4   = CON_IDLE ^ ((ONE << CON_EA) | (ONE << CON_LO_N));

  localparam logic [T_W-1:0] T_T1 = 6'b000001;
  localparam logic [T_W-1:0] T_T2 = 6'b000010;
  localparam logic [T_W-1:0] T_T3 = 6'b000100;
  localparam logic [T_W-1:0] T_T4 = 6'b001000;
  localparam logic [T_W-1:0] T_T5 = 6'b010000;
  localparam logic [T_W-1:0] T_T6 = 6'b100000;

  // Control word from ring state, opcode and halt flag; halt forces idle.
  function automatic logic [CON_W-1:0] con_decode(input logic [T_W-1:0]  t,
                                                  input logic [OP_W-1:0] op,
                                                  input logic            hlt);
    logic [CON_W-1:0] con;
    con = CON_IDLE;
    if (!hlt) begin
      case (t)
        T_T1: con = CON_FETCH_T1;
        T_T2: con = CON_FETCH_T2;
        T_T3: con = CON_FETCH_T3;
        T_T4: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB: con = CON_IR_MAR;
            OP_OUT:                 con = CON_OUT_T4;
            default:                con = CON_IDLE;
          endcase
        end
        T_T5: begin
          case (op)
            OP_LDA:         con = CON_LDA_T5;
            OP_ADD, OP_SUB: con = CON_LOAD_B;
            default:        con = CON_IDLE;
          endcase
        end
        T_T6: begin
          case (op)
            OP_ADD:  con = CON_ADD_T6;
            OP_SUB:  con = CON_SUB_T6;
            default: con = CON_IDLE;
          endcase
        end
        default: con = CON_IDLE;
      endcase
    end
    return con;
  endfunction

endpackage

// File: rtl/sap1_controller_sequencer_if.sv
// Sequencer <-> datapath bundle.
//   Opcode : IR upper nibble (datapath -> sequencer)
//   T      : one-hot ring state, T[0]=T1 .. T[5]=T6
//   Con    : 12-bit control word Cp Ep LmN CEN LiN EiN LaN Ea Su Eu LbN LoN
//   Hlt    : halt flag, gates the system clock externally
interface sap1_controller_sequencer_if;
  import sap1_controller_sequencer_pkg::*;

  logic [OP_W-1:0]  Opcode;
  logic [T_W-1:0]   T;
  logic [CON_W-1:0] Con;
  logic             Hlt;

  modport master (input Opcode, output T, output Con, output Hlt);
  modport slave  (output Opcode, input T, input Con, input Hlt);
endinterface

// File: rtl/sap1_controller_sequencer_ring_counter.sv
// Six-state one-hot ring counter, advancing on the falling clock edge.
//   clk      : clock (negedge active)
//   clr_n    : async active-low clear to T1
//   hold     : freeze the current state
//   early_t1 : return to T1 at this edge instead of advancing
//   t        : one-hot state
module sap1_controller_sequencer_ring_counter
  import sap1_controller_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           clr_n,
  input  logic           hold,
  input  logic           early_t1,
  output logic [T_W-1:0] t
);

  logic [T_W-1:0] t_q;
  logic [T_W-1:0] t_d;

  // Next state: hold wins over early return, which wins over rotation.
  always_comb begin
    t_d = t_q;
    if (hold) begin
      t_d = t_q;
    end else if (early_t1) begin
      t_d = T_T1;
    end else begin
      t_d = {t_q[T_W-2:0], t_q[T_W-1]};
    end
  end

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      t_q <= T_T1;
    end else begin
      t_q <= t_d;
    end
  end

  assign t = t_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter, control-word decode and halt latch.
//   Clk  : system clock, all state changes on negedge
//   ClrN : async active-low clear (shared with the program counter)
//   bus  : master side of sap1_controller_sequencer_if (Opcode in; T, Con, Hlt out)
// Optional: define SAP1_SEQ_EARLY_RESET_EN for a variable-length machine cycle
// (ring returns to T1 after the last non-idle state of the instruction).
module sap1_controller_sequencer
  import sap1_controller_sequencer_pkg::*;
(
  input  logic                           Clk,
  input  logic                           ClrN,
  sap1_controller_sequencer_if.master    bus
);

  logic [T_W-1:0] t;
  logic           hlt_q;
  logic           hlt_d;
  logic           halt_now;
  logic           hold;
  logic           early_t1;

  // HLT is recognised at the edge ending T4; from then on the ring is frozen.
  always_comb begin
    halt_now = t[3] && (bus.Opcode == OP_HLT);
    hlt_d    = hlt_q | halt_now;
    hold     = hlt_q | halt_now;
  end

`ifdef SAP1_SEQ_EARLY_RESET_EN
  // Early return to T1 once the instruction's remaining states would be idle.
  logic is_nop;
  always_comb begin
    is_nop   = !(bus.Opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});
    early_t1 = (t[2] && is_nop)
             | (t[3] && (bus.Opcode == OP_OUT))
             | (t[4] && (bus.Opcode == OP_LDA));
  end
`else
  always_comb begin
    early_t1 = 1'b0;
  end
`endif

  sap1_controller_sequencer_ring_counter u_ring (
    .clk      (Clk),
    .clr_n    (ClrN),
    .hold     (hold),
    .early_t1 (early_t1),
    .t        (t)
  );

  always_ff @(negedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      hlt_q <= 1'b0;
    end else begin
      hlt_q <= hlt_d;
    end
  end

  assign bus.T   = t;
  assign bus.Hlt = hlt_q;
  assign bus.Con = con_decode(t, bus.Opcode, hlt_q);

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
module tb_sap1_controller_sequencer;

  logic Clk  = 1'b0;
  logic ClrN = 1'b0;

  sap1_controller_sequencer_if bus();

  sap1_controller_sequencer dut (
    .Clk  (Clk),
    .ClrN (ClrN),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [18:0] sb_q[$];
  string       tag_q[$];

  int         m_t;
  bit         m_hlt;
  logic [3:0] op_drv;

`ifdef SAP1_SEQ_EARLY_RESET_EN
  localparam int LAT_LDA = 5;
  localparam int LAT_ADD = 6;
  localparam int LAT_OUT = 4;
  localparam int LAT_NOP = 3;
`else
  localparam int LAT_LDA = 6;
  localparam int LAT_ADD = 6;
  localparam int LAT_OUT = 6;
  localparam int LAT_NOP = 6;
`endif

  function automatic logic [11:0] exp_con(input int t, input logic [3:0] op, input bit h);
    if (h) return 12'h3E3;
    case (t)
      0: return 12'h5E3;
      1: return 12'hBE3;
      2: return 12'h263;
      3: case (op)
           4'h0, 4'h1, 4'h2: return 12'h1A3;
           4'hE:             return 12'h3F2;
           default:          return 12'h3E3;
         endcase
      4: case (op)
           4'h0:       return 12'h2C3;
           4'h1, 4'h2: return 12'h2E1;
           default:    return 12'h3E3;
         endcase
      5: case (op)
           4'h1:    return 12'h3C7;
           4'h2:    return 12'h3CF;
           default: return 12'h3E3;
         endcase
      default: return 12'h3E3;
    endcase
  endfunction

  // Index of the last ring state before returning to T1.
  function automatic int last_t(input logic [3:0] op);
`ifdef SAP1_SEQ_EARLY_RESET_EN
    case (op)
      4'h0:             return 4;
      4'h1, 4'h2, 4'hF: return 5;
      4'hE:             return 3;
      default:          return 2;
    endcase
`else
    return (op == 4'hF) ? 5 : 5;
`endif
  endfunction

  task automatic model_edge();
    if (!m_hlt) begin
      if (m_t == 3 && op_drv == 4'hF) m_hlt = 1'b1;
      else if (m_t == last_t(op_drv)) m_t = 0;
      else m_t = m_t + 1;
    end
  endtask

  task automatic model_reset();
    m_t   = 0;
    m_hlt = 1'b0;
  endtask

  task automatic push(input string tag);
    logic [5:0] t_exp;
    t_exp = 6'(1) << m_t;
    sb_q.push_back({t_exp, exp_con(m_t, op_drv, m_hlt), m_hlt});
    tag_q.push_back(tag);
  endtask

  task automatic check();
    logic [18:0] obs;
    logic [18:0] exp;
    string       tag;
    obs = {bus.T, bus.Con, bus.Hlt};
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed T=%b Con=%h Hlt=%b expected an entry", obs[18:13], obs[12:1], obs[0]);
    end else begin
      exp = sb_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed T=%b Con=%h Hlt=%b expected T=%b Con=%h Hlt=%b",
               tag, obs[18:13], obs[12:1], obs[0], exp[18:13], exp[12:1], exp[0]);
      end
    end
  endtask

  // One falling edge, sampled at the following rising edge.
  task automatic step(input string tag);
    @(negedge Clk);
    model_edge();
    push(tag);
    @(posedge Clk);
    #1;
    check();
  endtask

  task automatic run_instr(input logic [3:0] op, input int exp_lat, input string tag);
    int n;
    op_drv     = op;
    bus.Opcode = op;
    n = 0;
    do begin
      step(tag);
      n++;
    end while (m_t != 0 && !m_hlt && n < 8);
    vectors++;
    assert (n === exp_lat) else begin
      miscompares++;
      $error("FAIL %s_latency: observed %0d clocks expected %0d", tag, n, exp_lat);
    end
  endtask

  task automatic async_clear(input string tag);
    ClrN = 1'b0;
    #1;
    model_reset();
    push(tag);
    check();
    @(posedge Clk);
    #1;
    ClrN = 1'b1;
  endtask

  initial begin
    op_drv     = 4'h0;
    bus.Opcode = 4'h0;
    ClrN       = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    push("reset");
    check();
    ClrN = 1'b1;

    run_instr(4'h0, LAT_LDA, "lda");
    run_instr(4'h1, LAT_ADD, "add");
    run_instr(4'h2, LAT_ADD, "sub");
    run_instr(4'hE, LAT_OUT, "out");
    run_instr(4'h5, LAT_NOP, "nop5");
    run_instr(4'h0, LAT_LDA, "lda2");

    op_drv     = 4'hF;
    bus.Opcode = 4'hF;
    repeat (4)  step("hlt_enter");
    repeat (10) step("hlt_hold");
    async_clear("hlt_clear");

    op_drv     = 4'h1;
    bus.Opcode = 4'h1;
    repeat (4) step("add_pre_reset");
    async_clear("mid_reset");
    run_instr(4'h1, LAT_ADD, "add_after_reset");
    run_instr(4'h2, LAT_ADD, "sub_after_reset");

    vectors++;
    assert (sb_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
